// File: rtl/proc_run_controller.sv
// proc_run_controller: core reset/run sequencer with cycle and retire counters.
// Optional single-step gating of core_en under `RUN_CTRL_SINGLE_STEP_EN.
module proc_run_controller #(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 10,
    parameter int AUTO_START = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             halt_in,
    input  logic             retire,
`ifdef RUN_CTRL_SINGLE_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic             core_rst,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);
    typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, DONE} state_t;
    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ALL1 = '1;
    localparam state_t RST_STATE = (AUTO_START != 0) ? RST_HOLD : IDLE;
    state_t r_state, w_next;
    logic [HW-1:0] r_hold, w_hold_next;
    logic [CNT_W-1:0] w_cyc_inc, w_cyc_next, w_ret_next;
    logic w_timeout_next, w_step_ok, w_active;
`ifdef RUN_CTRL_SINGLE_STEP_EN
    assign w_step_ok = !step_mode || step;
`else
    assign w_step_ok = 1'b1;
`endif
    // core_en marks the cycles in which the core actually advances
    assign w_active  = (r_state == RUN) && core_en;
    assign w_cyc_inc = (cycle_count == ALL1) ? cycle_count : cycle_count + CNT_W'(1);
    always_comb begin
        w_next         = r_state;
        w_hold_next    = r_hold;
        w_cyc_next     = cycle_count;
        w_ret_next     = retire_count;
        w_timeout_next = timeout;
        case (r_state)
            IDLE, DONE: if (start) begin
                w_next         = RST_HOLD;
                w_hold_next    = HW'(RST_CYCLES - 1);
                w_cyc_next     = '0;
                w_ret_next     = '0;
                w_timeout_next = 1'b0;
            end
            RST_HOLD: begin
                if (r_hold == '0) w_next = RUN;
                else w_hold_next = r_hold - HW'(1);
            end
            RUN: if (w_active) begin
                w_cyc_next = w_cyc_inc;
                w_ret_next = (retire && retire_count != ALL1) ? retire_count + CNT_W'(1) : retire_count;
                // halt takes priority over budget exhaustion
                if (halt_in) w_next = DONE;
                else if (MAX_CYCLES != 0 && w_cyc_inc == CNT_W'(MAX_CYCLES)) begin
                    w_next         = DONE;
                    w_timeout_next = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= RST_STATE;
            r_hold       <= HW'(RST_CYCLES - 1);
            core_rst     <= 1'b1;
            core_en      <= 1'b0;
            busy         <= (AUTO_START != 0);
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            r_state      <= w_next;
            r_hold       <= w_hold_next;
            core_rst     <= (w_next == IDLE) || (w_next == RST_HOLD);
            core_en      <= (w_next == RUN) && w_step_ok;
            busy         <= (w_next == RST_HOLD) || (w_next == RUN);
            done         <= (w_next == DONE);
            timeout      <= w_timeout_next;
            cycle_count  <= w_cyc_next;
            retire_count <= w_ret_next;
        end
    end
endmodule

// File: tb/tb_proc_run_controller.sv
// tb_proc_run_controller: randomized runs on a default instance and a 3-bit unbounded instance,
// scoreboarded against a per-run reference model.
module tb_proc_run_controller;
    typedef struct {int cyc; int ret; int to; int en; int hold;} exp_t;
    logic Clk = 0, Reset = 0, start = 0, halt_in = 0, retire = 0;
`ifdef RUN_CTRL_SINGLE_STEP_EN
    logic step_mode = 0, step = 0;
`endif
    logic a_rst, a_en, a_busy, a_done, a_to, b_rst, b_en, b_busy, b_done, b_to;
    logic [31:0] a_cyc, a_ret;
    logic [2:0] b_cyc, b_ret;
    exp_t qa[$], qb[$];
    int n_cmp = 0, n_bad = 0;
    int hold_n[2], en_n[2];
    logic [1:0] pdone = '0, pbusy = '0;

    always #5 Clk = ~Clk;

    proc_run_controller u_a (
        .Clk(Clk), .Reset(Reset), .start(start), .halt_in(halt_in), .retire(retire),
`ifdef RUN_CTRL_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .core_rst(a_rst), .core_en(a_en), .busy(a_busy), .done(a_done), .timeout(a_to),
        .cycle_count(a_cyc), .retire_count(a_ret));

    proc_run_controller #(.CNT_W(3), .MAX_CYCLES(0)) u_b (
        .Clk(Clk), .Reset(Reset), .start(start), .halt_in(halt_in), .retire(retire),
`ifdef RUN_CTRL_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .core_rst(b_rst), .core_en(b_en), .busy(b_busy), .done(b_done), .timeout(b_to),
        .cycle_count(b_cyc), .retire_count(b_ret));

    task automatic chk(input string n, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Monitor: per-run hold/enable cycle counts, compared when done rises
    always @(negedge Clk) begin
        logic [1:0] d, b, r, e, t;
        int c[2], rt[2];
        exp_t x;
        d = {b_done, a_done}; b = {b_busy, a_busy}; r = {b_rst, a_rst};
        e = {b_en, a_en}; t = {b_to, a_to};
        c[0] = int'(a_cyc); c[1] = int'(b_cyc);
        rt[0] = int'(a_ret); rt[1] = int'(b_ret);
        for (int i = 0; i < 2; i++) begin
            if (b[i] && !pbusy[i]) begin
                hold_n[i] = 0;
                en_n[i] = 0;
                chk($sformatf("clr_cyc%0d", i), c[i], 0);
                chk($sformatf("clr_ret%0d", i), rt[i], 0);
                chk($sformatf("clr_to%0d", i), int'(t[i]), 0);
            end
            if (b[i] && r[i]) hold_n[i]++;
            if (e[i]) en_n[i]++;
            if (d[i] && !pdone[i]) begin
                if ((i == 0 ? qa.size() : qb.size()) == 0) chk($sformatf("sb_empty%0d", i), 1, 0);
                else begin
                    x = (i == 0) ? qa.pop_front() : qb.pop_front();
                    chk($sformatf("cyc%0d", i), c[i], x.cyc);
                    chk($sformatf("ret%0d", i), rt[i], x.ret);
                    chk($sformatf("to%0d", i), int'(t[i]), x.to);
                    chk($sformatf("en_cycles%0d", i), en_n[i], x.en);
                    chk($sformatf("hold_cycles%0d", i), hold_n[i], x.hold);
                end
            end
        end
        pdone = d;
        pbusy = b;
    end

    // One run: halt on RUN cycle h, stray start on RUN cycle s; abort asserts Reset in RUN cycle 3
    task automatic run(input int h, input int s, input bit abort);
        bit pat[1:20];
        int len_a, sa, sb;
        sa = 0; sb = 0;
        for (int k = 1; k <= 20; k++) pat[k] = 1'($urandom_range(0, 1));
        len_a = (h <= 10) ? h : 10;
        for (int k = 1; k <= h; k++) begin
            sb += int'(pat[k]);
            if (k <= len_a) sa += int'(pat[k]);
        end
        if (!abort) begin
            qa.push_back(exp_t'{len_a, sa, (h > 10) ? 1 : 0, len_a, 2});
            qb.push_back(exp_t'{(h < 7) ? h : 7, (sb < 7) ? sb : 7, 0, h, 2});
        end
        @(posedge Clk); #1;
        start = 1;
        halt_in = 1'($urandom_range(0, 1));
        retire = 1'($urandom_range(0, 1));
        for (int j = 1; j <= h + 4; j++) begin
            int k;
            k = j - 2;
            @(posedge Clk); #1;
            start = (j == 1) ? 1'($urandom_range(0, 1)) : (k == s);
            if (k >= 1 && k <= h) begin
                retire = pat[k];
                halt_in = (k == h);
            end else begin
                retire = 1'($urandom_range(0, 1));
                halt_in = 1'($urandom_range(0, 1));
            end
            if (abort && k == 3) begin
                #2 Reset = 1;
                #1;
                chk("async_rst_a", int'(a_rst), 1);
                chk("async_en_a", int'(a_en), 0);
                chk("async_rst_b", int'(b_rst), 1);
                chk("async_en_b", int'(b_en), 0);
                @(posedge Clk); #1;
                Reset = 0;
                start = 0;
                @(negedge Clk);
                chk("post_rst_cyc", int'(a_cyc), 0);
                chk("post_rst_ret", int'(a_ret), 0);
                chk("post_rst_busy", int'(a_busy), 0);
                chk("post_rst_core_rst", int'(a_rst), 1);
                chk("post_rst_done", int'(a_done), 0);
                return;
            end
        end
        start = 0;
    endtask

    initial begin
        int dir_h[6] = '{4, 10, 11, 16, 1, 12};
        int h;
        #2 Reset = 1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_core_rst", int'(a_rst), 1);
        chk("rst_core_en", int'(a_en), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_timeout", int'(a_to), 0);
        chk("rst_cyc", int'(a_cyc), 0);
        @(posedge Clk); #1;
        Reset = 0;
        repeat (2) @(posedge Clk);
        for (int i = 0; i < 6; i++) run(dir_h[i], 0, 0);
        run(16, 1, 1);
        for (int i = 0; i < 25; i++) begin
            h = $urandom_range(1, 16);
            run(h, $urandom_range(0, (h <= 10) ? h : 10), 0);
        end
`ifdef RUN_CTRL_SINGLE_STEP_EN
        begin
            int en_cnt;
            en_cnt = 0;
            step_mode = 1;
            @(posedge Clk); #1;
            start = 1;
            halt_in = 0;
            retire = 1;
            for (int j = 1; j <= 20; j++) begin
                @(posedge Clk); #1;
                start = 0;
                step = (j == 4 || j == 8 || j == 12);
                @(negedge Clk);
                en_cnt += int'(a_en);
            end
            chk("step_en_cycles", en_cnt, 3);
            chk("step_cyc", int'(a_cyc), 3);
            chk("step_ret", int'(a_ret), 3);
            step_mode = 0;
            @(posedge Clk); #1;
            Reset = 1;
            @(posedge Clk); #1;
            Reset = 0;
        end
`endif
        repeat (4) @(posedge Clk);
        chk("sb_drain_a", qa.size(), 0);
        chk("sb_drain_b", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
